alu_lane_cluster: RTL

- Parametrised N-lane integer ALU cluster for the superscalar issue path; successor to the fixed two-ALU wrapper.
- Executes up to NrLanes ALU ops per cycle, with intra-bundle forwarding along a lane chain. A younger lane may read any older lane's same-cycle result.
- Adds cross-cycle forwarding from the previous bundle's results and a registered, back-pressured result stage toward writeback.

---
 rtl/alu_lane_cluster.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_lane_cluster.sv
// alu_lane_cluster
//   N-lane integer ALU cluster for the superscalar issue path. Lane 0 is the
//   oldest op in a bundle. Each lane's operands may come from the port, from an
//   older lane's same-cycle result (combinational chain), or from any lane's
//   last committed result (cross-cycle forwarding). Results sit in a
//   one-entry, back-pressured output register toward writeback.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               kill the held bundle and any incoming bundle
//   valid_i/op_i          per-lane op valid and opcode
//   operand_a_i/_b_i      per-lane rs1/rs2 values
//   trans_id_i            per-lane scoreboard id
//   fwd_a_src_i/_b_src_i  per-lane operand source selects
//   ready_o               cluster accepts a bundle this cycle
//   result_valid_o        per-lane result valid
//   result_o/trans_id_o   per-lane results and their ids
//   result_ready_i        writeback consumes the whole output bundle
module alu_lane_cluster #(
  parameter  int unsigned NrLanes     = 2,
  parameter  int unsigned XLEN        = 64,
  parameter  int unsigned TransIdBits = 3,
  localparam int unsigned SrcW        = $clog2(2*NrLanes+1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NrLanes-1:0]                   valid_i,
  input  logic [NrLanes-1:0][2:0]              op_i,
  input  logic [NrLanes-1:0][XLEN-1:0]         operand_a_i,
  input  logic [NrLanes-1:0][XLEN-1:0]         operand_b_i,
  input  logic [NrLanes-1:0][TransIdBits-1:0]  trans_id_i,
  input  logic [NrLanes-1:0][SrcW-1:0]         fwd_a_src_i,
  input  logic [NrLanes-1:0][SrcW-1:0]         fwd_b_src_i,
  output logic                                 ready_o,
  output logic [NrLanes-1:0]                   result_valid_o,
  output logic [NrLanes-1:0][XLEN-1:0]         result_o,
  output logic [NrLanes-1:0][TransIdBits-1:0]  trans_id_o,
  input  logic                                 result_ready_i
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_CPOP = 3'd7
  } op_e;

  function automatic logic [XLEN-1:0] popcount(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] c;
    c = '0;
    for (int k = 0; k < XLEN; k++) c = c + XLEN'(v[k]);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op_e'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[ShW-1:0];
      OP_SRL:  r = a >> b[ShW-1:0];
      default: r = popcount(a);
    endcase
    return r;
  endfunction

  logic [NrLanes-1:0][XLEN-1:0]        w_res_p0;
  logic                                w_accept_p0;

  logic [NrLanes-1:0]                  r_vld_p1;
  logic [NrLanes-1:0][XLEN-1:0]        r_res_p1;
  logic [NrLanes-1:0][TransIdBits-1:0] r_tid_p1;
  logic [NrLanes-1:0][XLEN-1:0]        r_last_p1;

  // Stage p0: operand forwarding and lane execution. Lanes are evaluated
  // oldest first so a younger lane sees the finished result of any older lane;
  // selects that name a younger/same lane, an invalid lane, or an out-of-range
  // value fall back to the port operand.
  always_comb begin
    logic [XLEN-1:0] opa, opb;
    w_res_p0 = '0;
    for (int i = 0; i < NrLanes; i++) begin
      opa = operand_a_i[i];
      opb = operand_b_i[i];
      for (int j = 0; j < NrLanes; j++) begin
        if (j < i && valid_i[j] && int'(fwd_a_src_i[i]) == j + 1) opa = w_res_p0[j];
        if (j < i && valid_i[j] && int'(fwd_b_src_i[i]) == j + 1) opb = w_res_p0[j];
        if (int'(fwd_a_src_i[i]) == NrLanes + 1 + j) opa = r_last_p1[j];
        if (int'(fwd_b_src_i[i]) == NrLanes + 1 + j) opb = r_last_p1[j];
      end
      w_res_p0[i] = alu_exec(op_i[i], opa, opb);
    end
  end

  assign ready_o     = !(|r_vld_p1) || result_ready_i;
  assign w_accept_p0 = (|valid_i) && ready_o && !flush_i;

  // Stage p1: output register and last-result registers. Flush beats both a
  // new bundle and a drain; invalid lanes keep their previous result, id and
  // last-result value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1  <= '0;
      r_res_p1  <= '0;
      r_tid_p1  <= '0;
      r_last_p1 <= '0;
    end else if (flush_i) begin
      r_vld_p1 <= '0;
    end else if (w_accept_p0) begin
      r_vld_p1 <= valid_i;
      for (int k = 0; k < NrLanes; k++) begin
        if (valid_i[k]) begin
          r_res_p1[k]  <= w_res_p0[k];
          r_tid_p1[k]  <= trans_id_i[k];
          r_last_p1[k] <= w_res_p0[k];
        end
      end
    end else if (result_ready_i) begin
      r_vld_p1 <= '0;
    end
  end

  assign result_valid_o = r_vld_p1;
  assign result_o       = r_res_p1;
  assign trans_id_o     = r_tid_p1;

endmodule
